pixel_enhance_pipe: RTL and testbench
=====================================

Name: pixel_enhance_pipe

Overview:
Parametrised successor to the fixed RGB565 enhancement stage in the image processor. It streams pixels through a 2-stage valid/ready pipeline and tracks raster position with internal x/y counters. Each pixel gets a per-frame selectable enhancement mode (pass, brighten, darken, invert), and a face bounding box can be overlaid in a fixed colour. It sits between the camera pixel stream and the display/output formatter, fed with box coordinates by the face detector.

Parameters:
R_W, 5, red field width (MSBs of pixel)
G_W, 6, green field width
B_W, 5, blue field width (LSBs); PIX_W = R_W+G_W+B_W
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame
XY_W, 10, coordinate width; must satisfy 2^XY_W >= max(IMG_W, IMG_H)
BOX_COLOR, all-ones of PIX_W, overlay colour

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_pixel  in  PIX_W  input pixel {R,G,B}
in_valid  in  1  input pixel valid
in_sof  in  1  start-of-frame, qualifies in_valid
in_ready  out  1  block can accept a pixel
mode  in  2  0 pass, 1 brighten, 2 darken, 3 invert
shift  in  3  enhancement strength
box_en  in  1  enable face-box overlay
box_x, box_y  in  XY_W each  box top-left
box_w, box_h  in  XY_W each  box size
out_pixel  out  PIX_W  processed pixel
out_valid  out  1  output valid
out_ready  in  1  downstream accept
out_x, out_y  out  XY_W each  coordinates of out_pixel
out_sof  out  1  out_pixel is (0,0)
out_eol  out  1  out_pixel is last in its line
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted at output

Behaviour:
- Reset (async, rst_n=0): all pipeline valids, out_* (pixel, valid, x, y, sof, eol), frame_done, the x/y counters and the latched config go to 0. in_ready is 1 out of reset. Reset mid-frame discards in-flight pixels.
- Handshake: advance = out_ready | ~out_valid. in_ready = advance. Both stages shift together on advance, and bubbles propagate. A transfer occurs when a valid is high with its ready in the same cycle. On stall, out_* stay stable.
- Latency: 2 cycles from input acceptance to out_valid when not stalled. Throughput is 1 pixel/clk.
- Counters (stage 1, on accepted input):
  - in_sof=1: the pixel is tagged (0,0).
  - Otherwise the pixel is tagged with the current counter. x then increments. At x=IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1) both wrap to 0.
  - A pixel tagged (IMG_W-1, IMG_H-1) carries an end-of-frame flag.
- Config latch: mode, shift, box_en and box_* are sampled on acceptance of every pixel tagged (0,0). They apply to that whole frame, and mid-frame changes are ignored.
- Enhancement (stage 1, per channel c, MAX = 2^W-1 for that field), with all arithmetic at field width:
  - Brighten: c + ((MAX-c) >> shift). This never overflows; shift=0 gives MAX.
  - Darken: c - (c >> shift). shift=0 gives 0.
  - Invert: MAX - c.
  - Pass: c.
- Overlay (stage 2), with x1 = box_x+box_w-1 and y1 = box_y+box_h-1, computed at XY_W+1 bits:
  - A pixel is on the border if box_en is set, box_w≠0, box_h≠0, and either:
    - (x==box_x or x==x1) and box_y<=y<=y1, or
    - (y==box_y or y==y1) and box_x<=x<=x1.
  - Border pixels output BOX_COLOR in place of the enhanced value.
  - Box parts outside the image simply never match.
- out_eol=1 when out_x==IMG_W-1. out_sof=1 when out_x==0 and out_y==0.
- frame_done pulses for exactly 1 cycle on the output transfer of the end-of-frame-flagged pixel.
- An in_sof mid-frame restarts the count and re-latches config. No error flag is raised.

Test Plan:
- Reset then pass: mode=0, stream 8 pixels of 16'h1234 with out_ready=1 -> out_pixel=16'h1234, out_valid rises 2 cycles after the first acceptance, x=0..7, out_sof only on the first.
- Arithmetic, brighten: mode=1, shift=1, pixel {R=5'd10,G=6'd20,B=5'd0} -> {R=20,G=41,B=15}.
- Arithmetic, other modes: shift=0 brighten -> 16'hFFFF. mode=2, shift=2, R=5'd12 -> R=9. mode=3 on 16'h0000 -> 16'hFFFF.
- Box: IMG_W=IMG_H=8, box_en=1, box (2,2), w=3, h=3 -> BOX_COLOR exactly at the 8 border pixels of x,y∈[2,4]; centre (3,3) and all others keep the enhanced value; box_w=0 -> no overlay.
- Backpressure: random out_ready at 50%, stream 64 pixels -> no loss or duplication, out_* stable while stalled, in_ready tracks advance.
- Frame wrap and reset: IMG_W=4, IMG_H=2, stream 8 pixels -> frame_done one pulse on pixel (3,1), the next pixel is (0,0). Change mode at pixel 3 -> no effect until the next frame. Assert rst_n low mid-frame -> all outputs 0 at once, counting restarts at (0,0).

Source files
------------

// File: rtl/pixel_enhance_pipe.sv
// Two-stage RGB pixel enhancement pipeline: per-channel brighten/darken/invert
// in stage 1, face bounding-box overlay in stage 2, with raster position tracking.
module pixel_enhance_pipe #(
    parameter int R_W   = 5,
    parameter int G_W   = 6,
    parameter int B_W   = 5,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XY_W  = 10,
    parameter logic [R_W+G_W+B_W-1:0] BOX_COLOR = '1,
    localparam int PIX_W = R_W + G_W + B_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [2:0]       shift,
    input  logic             box_en,
    input  logic [XY_W-1:0]  box_x,
    input  logic [XY_W-1:0]  box_y,
    input  logic [XY_W-1:0]  box_w,
    input  logic [XY_W-1:0]  box_h,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XY_W-1:0]  out_x,
    output logic [XY_W-1:0]  out_y,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done
);

    localparam int CW = (R_W > G_W) ? ((R_W > B_W) ? R_W : B_W)
                                    : ((G_W > B_W) ? G_W : B_W);
    localparam logic [XY_W-1:0] X_LAST = XY_W'(IMG_W - 1);
    localparam logic [XY_W-1:0] Y_LAST = XY_W'(IMG_H - 1);
    localparam logic [XY_W:0]   ONE_E  = (XY_W+1)'(1);

    // Evaluated at the widest field width; with cmax set to the field's own
    // maximum the results are identical to field-width arithmetic.
    function automatic logic [CW-1:0] enh_ch(input logic [CW-1:0] c,
                                             input logic [CW-1:0] cmax,
                                             input logic [1:0]    m,
                                             input logic [2:0]    sh);
        logic [CW-1:0] r;
        case (m)
            2'd1:    r = c + ((cmax - c) >> sh);
            2'd2:    r = c - (c >> sh);
            2'd3:    r = cmax - c;
            default: r = c;
        endcase
        return r;
    endfunction

    logic [XY_W-1:0]  cnt_x_q, cnt_x_d;
    logic [XY_W-1:0]  cnt_y_q, cnt_y_d;

    logic [1:0]       cfg_mode_q, cfg_mode_d;
    logic [2:0]       cfg_shift_q, cfg_shift_d;
    logic             cfg_box_en_q, cfg_box_en_d;
    logic [XY_W-1:0]  cfg_box_x_q, cfg_box_x_d;
    logic [XY_W-1:0]  cfg_box_y_q, cfg_box_y_d;
    logic [XY_W-1:0]  cfg_box_w_q, cfg_box_w_d;
    logic [XY_W-1:0]  cfg_box_h_q, cfg_box_h_d;

    logic             s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0] s1_pix_q, s1_pix_d;
    logic [XY_W-1:0]  s1_x_q, s1_x_d;
    logic [XY_W-1:0]  s1_y_q, s1_y_d;
    logic             s1_eof_q, s1_eof_d;

    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
    logic [XY_W-1:0]  out_x_q, out_x_d;
    logic [XY_W-1:0]  out_y_q, out_y_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;

    logic             advance;
    logic             accept;
    logic [XY_W-1:0]  tag_x, tag_y;
    logic             tag_first;
    logic             tag_eof;
    logic [1:0]       eff_mode;
    logic [2:0]       eff_shift;
    logic [CW-1:0]    r_enh, g_enh, b_enh;
    logic [PIX_W-1:0] enh_pix;
    logic [XY_W:0]    bx0, by0, bx1, by1, px, py;
    logic             in_xr, in_yr, on_vert, on_horz, border;

    assign advance  = out_ready | ~out_valid_q;
    assign accept   = in_valid & advance;
    assign in_ready = advance;

    // Stage 1: raster tagging, counter update and config capture.
    always_comb begin
        tag_x     = in_sof ? '0 : cnt_x_q;
        tag_y     = in_sof ? '0 : cnt_y_q;
        tag_first = (tag_x == '0) && (tag_y == '0);
        tag_eof   = (tag_x == X_LAST) && (tag_y == Y_LAST);

        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (accept) begin
            if (tag_x == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (tag_y == Y_LAST) ? '0 : tag_y + 1'b1;
            end else begin
                cnt_x_d = tag_x + 1'b1;
                cnt_y_d = tag_y;
            end
        end

        cfg_mode_d   = cfg_mode_q;
        cfg_shift_d  = cfg_shift_q;
        cfg_box_en_d = cfg_box_en_q;
        cfg_box_x_d  = cfg_box_x_q;
        cfg_box_y_d  = cfg_box_y_q;
        cfg_box_w_d  = cfg_box_w_q;
        cfg_box_h_d  = cfg_box_h_q;
        if (accept && tag_first) begin
            cfg_mode_d   = mode;
            cfg_shift_d  = shift;
            cfg_box_en_d = box_en;
            cfg_box_x_d  = box_x;
            cfg_box_y_d  = box_y;
            cfg_box_w_d  = box_w;
            cfg_box_h_d  = box_h;
        end

        // The first pixel of a frame already uses the config it latches.
        eff_mode  = tag_first ? mode  : cfg_mode_q;
        eff_shift = tag_first ? shift : cfg_shift_q;

        r_enh = enh_ch(CW'(in_pixel[PIX_W-1 -: R_W]), CW'({R_W{1'b1}}), eff_mode, eff_shift);
        g_enh = enh_ch(CW'(in_pixel[B_W +: G_W]),     CW'({G_W{1'b1}}), eff_mode, eff_shift);
        b_enh = enh_ch(CW'(in_pixel[B_W-1:0]),        CW'({B_W{1'b1}}), eff_mode, eff_shift);
        enh_pix = {r_enh[R_W-1:0], g_enh[G_W-1:0], b_enh[B_W-1:0]};

        s1_valid_d = s1_valid_q;
        s1_pix_d   = s1_pix_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_eof_d   = s1_eof_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_pix_d = enh_pix;
                s1_x_d   = tag_x;
                s1_y_d   = tag_y;
                s1_eof_d = tag_eof;
            end
        end
    end

    // Stage 2: box border match against the config of the frame in stage 1.
    always_comb begin
        bx0 = {1'b0, cfg_box_x_q};
        by0 = {1'b0, cfg_box_y_q};
        bx1 = bx0 + {1'b0, cfg_box_w_q} - ONE_E;
        by1 = by0 + {1'b0, cfg_box_h_q} - ONE_E;
        px  = {1'b0, s1_x_q};
        py  = {1'b0, s1_y_q};

        in_xr   = (px >= bx0) && (px <= bx1);
        in_yr   = (py >= by0) && (py <= by1);
        on_vert = ((px == bx0) || (px == bx1)) && in_yr;
        on_horz = ((py == by0) || (py == by1)) && in_xr;
        border  = cfg_box_en_q && (cfg_box_w_q != '0) && (cfg_box_h_q != '0)
                  && (on_vert || on_horz);

        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_pixel_d = border ? BOX_COLOR : s1_pix_q;
                out_x_d     = s1_x_q;
                out_y_d     = s1_y_q;
                out_sof_d   = (s1_x_q == '0) && (s1_y_q == '0);
                out_eol_d   = (s1_x_q == X_LAST);
                out_eof_d   = s1_eof_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x_q      <= '0;
            cnt_y_q      <= '0;
            cfg_mode_q   <= '0;
            cfg_shift_q  <= '0;
            cfg_box_en_q <= 1'b0;
            cfg_box_x_q  <= '0;
            cfg_box_y_q  <= '0;
            cfg_box_w_q  <= '0;
            cfg_box_h_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_eof_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_box_en_q <= cfg_box_en_d;
            cfg_box_x_q  <= cfg_box_x_d;
            cfg_box_y_q  <= cfg_box_y_d;
            cfg_box_w_q  <= cfg_box_w_d;
            cfg_box_h_q  <= cfg_box_h_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_q     <= s1_pix_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_eof_q     <= s1_eof_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = out_valid_q & out_ready & out_eof_q;

endmodule

// File: tb/tb_pixel_enhance_pipe.sv
// Directed bench for pixel_enhance_pipe: an 8x8 instance for streaming/box tests
// and a 4x2 instance for frame wrap and mid-frame reset, sharing one stimulus.
module tb_pixel_enhance_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_pixel;
    logic        in_valid, in_sof;
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic        box_en;
    logic [9:0]  box_x, box_y, box_w, box_h;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sof_a, out_eol_a, frame_done_a;
    logic [15:0] out_pixel_a;
    logic [9:0]  out_x_a, out_y_a;
    logic        in_ready_b, out_valid_b, out_sof_b, out_eol_b, frame_done_b;
    logic [15:0] out_pixel_b;
    logic [9:0]  out_x_b, out_y_b;

    always #5 clk = ~clk;

    pixel_enhance_pipe #(.IMG_W(8), .IMG_H(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready_a), .mode(mode), .shift(shift),
        .box_en(box_en), .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .out_pixel(out_pixel_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_x(out_x_a), .out_y(out_y_a), .out_sof(out_sof_a), .out_eol(out_eol_a),
        .frame_done(frame_done_a));

    pixel_enhance_pipe #(.IMG_W(4), .IMG_H(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready_b), .mode(mode), .shift(shift),
        .box_en(box_en), .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .out_pixel(out_pixel_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_x(out_x_b), .out_y(out_y_b), .out_sof(out_sof_b), .out_eol(out_eol_b),
        .frame_done(frame_done_b));

    typedef struct {
        logic [15:0] p;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        sof;
        logic        eol;
        logic        fd;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int   fd_a, fd_b;
    int   n_pass, n_total;

    // Record every output transfer; values at the falling edge are those the
    // next rising edge will transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_a && out_ready)
                qa.push_back('{out_pixel_a, out_x_a, out_y_a, out_sof_a, out_eol_a, frame_done_a});
            if (out_valid_b && out_ready)
                qb.push_back('{out_pixel_b, out_x_b, out_y_b, out_sof_b, out_eol_b, frame_done_b});
            if (frame_done_a) fd_a++;
            if (frame_done_b) fd_b++;
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete(); qb.delete(); fd_a = 0; fd_b = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [15:0] p, input logic sof);
        bit acc;
        acc = 1'b0;
        in_pixel = p; in_sof = sof; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles (required 1)");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid_a); else n_pass++;
        n_total++; if (out_pixel_a !== 16'h0) $display("FAIL reset_out_pixel got %h exp 0000", out_pixel_a); else n_pass++;
        n_total++; if (out_x_a !== 10'd0 || out_y_a !== 10'd0) $display("FAIL reset_xy got %0d,%0d exp 0,0", out_x_a, out_y_a); else n_pass++;
        n_total++; if (out_sof_a !== 1'b0 || out_eol_a !== 1'b0) $display("FAIL reset_sof_eol got %b%b exp 00", out_sof_a, out_eol_a); else n_pass++;
        n_total++; if (frame_done_a !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done_a); else n_pass++;
        n_total++; if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready_a); else n_pass++;
    endtask

    task automatic test_pass;
        bit exp_v;
        do_reset();
        mode = 2'd0; shift = 3'd0; box_en = 1'b0;
        in_pixel = 16'h1234; in_sof = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_sof = 1'b0;
            if (k + 1 >= 8) in_valid = 1'b0;
            @(negedge clk);
            exp_v = (k >= 1 && k <= 8);
            n_total++; if (out_valid_a !== exp_v) $display("FAIL pass_valid k=%0d got %b exp %b", k, out_valid_a, exp_v); else n_pass++;
            if (exp_v) begin
                n_total++; if (out_pixel_a !== 16'h1234) $display("FAIL pass_pixel k=%0d got %h exp 1234", k, out_pixel_a); else n_pass++;
                n_total++; if (out_x_a !== 10'(k-1) || out_y_a !== 10'd0) $display("FAIL pass_xy k=%0d got %0d,%0d exp %0d,0", k, out_x_a, out_y_a, k-1); else n_pass++;
                n_total++; if (out_sof_a !== (k == 1)) $display("FAIL pass_sof k=%0d got %b exp %b", k, out_sof_a, (k == 1)); else n_pass++;
                n_total++; if (out_eol_a !== (k == 8)) $display("FAIL pass_eol k=%0d got %b exp %b", k, out_eol_a, (k == 8)); else n_pass++;
            end
        end
        idle(2);
    endtask

    task automatic test_arith;
        logic [15:0] pv [8];
        logic [1:0]  mv [8];
        logic [2:0]  sv [8];
        logic [15:0] ev [8];
        pv[0] = {5'd10, 6'd20, 5'd0};  mv[0] = 2'd1; sv[0] = 3'd1; ev[0] = {5'd20, 6'd41, 5'd15};
        pv[1] = 16'h1234;              mv[1] = 2'd1; sv[1] = 3'd0; ev[1] = 16'hFFFF;
        pv[2] = {5'd12, 6'd40, 5'd7};  mv[2] = 2'd2; sv[2] = 3'd2; ev[2] = {5'd9, 6'd30, 5'd6};
        pv[3] = 16'h0000;              mv[3] = 2'd3; sv[3] = 3'd0; ev[3] = 16'hFFFF;
        pv[4] = 16'h1234;              mv[4] = 2'd3; sv[4] = 3'd5; ev[4] = 16'hEDCB;
        pv[5] = {5'd31, 6'd0, 5'd1};   mv[5] = 2'd2; sv[5] = 3'd0; ev[5] = 16'h0000;
        pv[6] = {5'd0, 6'd63, 5'd30};  mv[6] = 2'd1; sv[6] = 3'd3; ev[6] = {5'd3, 6'd63, 5'd30};
        pv[7] = 16'h1234;              mv[7] = 2'd2; sv[7] = 3'd7; ev[7] = 16'h1234;
        box_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            qa.delete();
            mode = mv[i]; shift = sv[i];
            send_px(pv[i], 1'b1);
            idle(4);
            n_total++;
            if (qa.size() != 1) $display("FAIL arith_count case=%0d got %0d exp 1", i, qa.size());
            else if (qa[0].p !== ev[i]) $display("FAIL arith_pixel case=%0d got %h exp %h", i, qa[0].p, ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_box;
        logic [7:0]  rowmap [8];
        logic [15:0] e;
        int          x, y;
        rowmap[0] = 8'b0000_0000; rowmap[1] = 8'b0000_0000;
        rowmap[2] = 8'b0001_1100; rowmap[3] = 8'b0001_0100;
        rowmap[4] = 8'b0001_1100; rowmap[5] = 8'b0000_0000;
        rowmap[6] = 8'b0000_0000; rowmap[7] = 8'b0000_0000;
        for (int pass = 0; pass < 2; pass++) begin
            qa.delete(); fd_a = 0;
            mode = (pass == 0) ? 2'd3 : 2'd0; shift = 3'd0;
            box_en = 1'b1; box_x = 10'd2; box_y = 10'd2; box_h = 10'd3;
            box_w = (pass == 0) ? 10'd3 : 10'd0;
            for (int i = 0; i < 64; i++) send_px(16'h1234, i == 0);
            idle(4);
            n_total++; if (qa.size() != 64) $display("FAIL box_count pass=%0d got %0d exp 64", pass, qa.size()); else n_pass++;
            for (int i = 0; i < 64 && i < qa.size(); i++) begin
                x = i % 8; y = i / 8;
                if (pass == 0) e = rowmap[y][x] ? 16'hFFFF : 16'hEDCB;
                else           e = 16'h1234;
                n_total++;
                if (qa[i].p !== e || qa[i].x !== 10'(x) || qa[i].y !== 10'(y))
                    $display("FAIL box_pixel pass=%0d i=%0d got %h@(%0d,%0d) exp %h@(%0d,%0d)",
                             pass, i, qa[i].p, qa[i].x, qa[i].y, e, x, y);
                else n_pass++;
            end
            n_total++; if (fd_a != 1) $display("FAIL box_frame_done pass=%0d got %0d pulses exp 1", pass, fd_a); else n_pass++;
        end
        box_en = 1'b0;
    endtask

    task automatic test_backpressure;
        int          idx;
        bit          stalled, acc;
        logic [15:0] sp;
        logic [9:0]  sx, sy;
        logic [15:0] e;
        qa.delete(); fd_a = 0;
        mode = 2'd0; shift = 3'd0; box_en = 1'b0;
        idx = 0; stalled = 1'b0;
        in_pixel = 16'h0107; in_sof = 1'b1; in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 2000 && qa.size() < 64; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                n_total++;
                if (out_valid_a !== 1'b1 || out_pixel_a !== sp || out_x_a !== sx || out_y_a !== sy)
                    $display("FAIL bp_stable cyc=%0d got %b %h (%0d,%0d) exp 1 %h (%0d,%0d)",
                             cyc, out_valid_a, out_pixel_a, out_x_a, out_y_a, sp, sx, sy);
                else n_pass++;
            end
            n_total++;
            if (in_ready_a !== (out_ready | ~out_valid_a))
                $display("FAIL bp_in_ready cyc=%0d got %b exp %b", cyc, in_ready_a, out_ready | ~out_valid_a);
            else n_pass++;
            stalled = out_valid_a && !out_ready;
            sp = out_pixel_a; sx = out_x_a; sy = out_y_a;
            acc = in_valid && in_ready_a;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_sof = 1'b0;
                if (idx < 64) in_pixel = 16'(idx * 16'h0321 + 16'h0107);
                else in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        idle(4);
        n_total++; if (qa.size() != 64) $display("FAIL bp_count got %0d exp 64", qa.size()); else n_pass++;
        for (int i = 0; i < 64 && i < qa.size(); i++) begin
            e = 16'(i * 16'h0321 + 16'h0107);
            n_total++;
            if (qa[i].p !== e || qa[i].x !== 10'(i % 8) || qa[i].y !== 10'(i / 8))
                $display("FAIL bp_order i=%0d got %h@(%0d,%0d) exp %h@(%0d,%0d)",
                         i, qa[i].p, qa[i].x, qa[i].y, e, i % 8, i / 8);
            else n_pass++;
        end
        n_total++; if (fd_a != 1) $display("FAIL bp_frame_done got %0d pulses exp 1", fd_a); else n_pass++;
    endtask

    task automatic test_wrap;
        do_reset();
        mode = 2'd0; shift = 3'd0; box_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) mode = 2'd3;
            send_px(16'h1234, 1'b0);
        end
        idle(4);
        n_total++; if (qb.size() != 9) $display("FAIL wrap_count got %0d exp 9", qb.size()); else n_pass++;
        for (int i = 0; i < 8 && i < qb.size(); i++) begin
            n_total++;
            if (qb[i].p !== 16'h1234 || qb[i].x !== 10'(i % 4) || qb[i].y !== 10'(i / 4) ||
                qb[i].fd !== (i == 7) || qb[i].eol !== (i % 4 == 3) || qb[i].sof !== (i == 0))
                $display("FAIL wrap_pixel i=%0d got %h@(%0d,%0d) sof%b eol%b fd%b exp 1234@(%0d,%0d) sof%b eol%b fd%b",
                         i, qb[i].p, qb[i].x, qb[i].y, qb[i].sof, qb[i].eol, qb[i].fd,
                         i % 4, i / 4, (i == 0), (i % 4 == 3), (i == 7));
            else n_pass++;
        end
        if (qb.size() == 9) begin
            n_total++;
            if (qb[8].p !== 16'hEDCB || qb[8].x !== 10'd0 || qb[8].y !== 10'd0 || qb[8].sof !== 1'b1)
                $display("FAIL wrap_next_frame got %h@(%0d,%0d) sof%b exp edcb@(0,0) sof1",
                         qb[8].p, qb[8].x, qb[8].y, qb[8].sof);
            else n_pass++;
        end
        n_total++; if (fd_b != 1) $display("FAIL wrap_frame_done got %0d pulses exp 1", fd_b); else n_pass++;
    endtask

    task automatic test_midreset;
        do_reset();
        mode = 2'd0; shift = 3'd0; box_en = 1'b0;
        send_px(16'hAAAA, 1'b0);
        send_px(16'hBBBB, 1'b0);
        send_px(16'hCCCC, 1'b0);
        n_total++; if (out_valid_b !== 1'b1 || out_x_b !== 10'd1) $display("FAIL midrst_pre got v%b x%0d exp v1 x1", out_valid_b, out_x_b); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid_b !== 1'b0 || out_pixel_b !== 16'h0 || out_x_b !== 10'd0 || out_y_b !== 10'd0 ||
            out_sof_b !== 1'b0 || out_eol_b !== 1'b0 || frame_done_b !== 1'b0 || in_ready_b !== 1'b1)
            $display("FAIL midrst_outputs got v%b p%h (%0d,%0d) sof%b eol%b fd%b rdy%b exp all 0, rdy1",
                     out_valid_b, out_pixel_b, out_x_b, out_y_b, out_sof_b, out_eol_b, frame_done_b, in_ready_b);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qb.delete();
        @(posedge clk);
        #1;
        send_px(16'h0F0F, 1'b0);
        idle(4);
        n_total++;
        if (qb.size() != 1) $display("FAIL midrst_count got %0d exp 1", qb.size());
        else if (qb[0].p !== 16'h0F0F || qb[0].x !== 10'd0 || qb[0].y !== 10'd0 || qb[0].sof !== 1'b1)
            $display("FAIL midrst_restart got %h@(%0d,%0d) sof%b exp 0f0f@(0,0) sof1", qb[0].p, qb[0].x, qb[0].y, qb[0].sof);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; fd_a = 0; fd_b = 0;
        rst_n = 1'b0; in_pixel = '0; in_valid = 1'b0; in_sof = 1'b0;
        mode = '0; shift = '0; box_en = 1'b0;
        box_x = '0; box_y = '0; box_w = '0; box_h = '0;
        out_ready = 1'b1;
        test_reset();
        test_pass();
        test_arith();
        test_box();
        test_backpressure();
        test_wrap();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
